// File: rtl/msrv32_wb_integer_file.sv
// msrv32_wb_integer_file: RV32I register file with write-first bypass and committed-write counter.
// Revision: 1.0
`default_nettype none

module msrv32_wb_integer_file #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 32
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic [ADDR_W-1:0] rs_1_addr_in,
   input  logic [ADDR_W-1:0] rs_2_addr_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   input  logic              wr_en_in,
   input  logic              flush_in,
   input  logic [DATA_W-1:0] rd_in,
   output logic [DATA_W-1:0] rs_1_out,
   output logic [DATA_W-1:0] rs_2_out,
   output logic [CNT_W-1:0]  wr_count_out
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [CNT_W-1:0]  wr_count;
   logic              we;
   logic              bypass_en;

   assign we        = wr_en_in & ~flush_in & (rd_addr_in != '0);
   // Reset kills the write, so it must not be forwarded either.
   assign bypass_en = we & ~reset_in;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (we) begin
         regs[rd_addr_in] <= rd_in;
         wr_count         <= wr_count + CNT_W'(1);
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] data;
      data = regs[addr];
      if (addr == '0) begin
         data = '0;
      end else if (bypass_en && (addr == rd_addr_in)) begin
         data = rd_in;
      end
      return data;
   endfunction

   always_comb begin
      rs_1_out = read_port(rs_1_addr_in);
      rs_2_out = read_port(rs_2_addr_in);
   end

   assign wr_count_out = wr_count;

endmodule

`default_nettype wire
